// File: rtl/cache_pkg.sv
// Shared definitions for the cache line adaptor.
// Holds the line and burst geometry, the adaptor state encoding and a helper
// that aligns a byte address to the start of its cache line.
package cache_pkg;

    localparam int S_OFFSET  = 5;                    // line offset bits
    localparam int S_LINE    = 8 * (2 ** S_OFFSET);  // 256-bit line
    localparam int S_BURST   = 64;                   // memory beat width
    localparam int NUM_BEATS = S_LINE / S_BURST;     // beats per line
    localparam int BEAT_BITS = $clog2(NUM_BEATS);

    // Clears the byte-offset bits so the burst starts on a line boundary.
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << S_OFFSET) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } adaptor_state_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/cacheline_adaptor_beat_counter.sv
// Beat counter for one line burst.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   inc_i     : advance to the next beat (wraps after the last beat)
//   clr_i     : force the count back to beat 0
//   count_o   : index of the current beat
//   last_o    : high while the current beat is the final one of the line
module beat_counter
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [BEAT_BITS-1:0] count_o,
    output logic                 last_o
);

    logic [BEAT_BITS-1:0] count_q;
    logic [BEAT_BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            // NUM_BEATS is a power of two, so natural overflow is the wrap.
            count_d = count_q + BEAT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == BEAT_BITS'(NUM_BEATS - 1));

endmodule

// File: rtl/cacheline_adaptor.sv
// Cache line adaptor: bridges the cache's 256-bit line port to a 64-bit
// burst memory port. A line read becomes a 4-beat burst fill, a line
// write-back becomes a 4-beat burst write, and the cache controller gets a
// single-cycle completion pulse once the burst has finished.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   line_i / line_o     : write-back line in / assembled fill line out
//   address_i           : line address from the cache
//   read_i / write_i    : cache requests, held until resp_o
//   resp_o              : one-cycle completion pulse to the cache
//   burst_i / burst_o   : memory read beat in / memory write beat out
//   address_o           : line-aligned burst base address
//   read_o / write_o    : memory burst requests
//   resp_i              : memory beat strobe, one beat per high cycle
module cacheline_adaptor
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [S_LINE-1:0]  line_i,
    output logic [S_LINE-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [S_BURST-1:0] burst_i,
    output logic [S_BURST-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    adaptor_state_t state_q;

    logic [NUM_BEATS-1:0][S_BURST-1:0] line_q;   // fill line, beat-indexed
    logic [NUM_BEATS-1:0][S_BURST-1:0] wbuf_q;   // write-back snapshot
    logic [31:0]                       addr_q;
    logic                              read_q;
    logic                              write_q;
    logic                              resp_q;

    logic [BEAT_BITS-1:0]              count;
    logic                              last_beat;
    logic                              beat_xfer;

    // A beat moves only while a burst is active; strobes elsewhere are ignored.
    assign beat_xfer = resp_i && ((state_q == RD_BURST) || (state_q == WR_BURST));

    beat_counter u_beat_counter (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (beat_xfer),
        .clr_i   (state_q == IDLE),
        .count_o (count),
        .last_o  (last_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            wbuf_q  <= '0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_q <= 1'b0;
                    // Write-back wins so a dirty victim leaves before the fill.
                    if (write_i) begin
                        wbuf_q  <= line_i;
                        addr_q  <= line_align(address_i);
                        write_q <= 1'b1;
                        state_q <= WR_BURST;
                    end else if (read_i) begin
                        addr_q  <= line_align(address_i);
                        read_q  <= 1'b1;
                        state_q <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        line_q[count] <= burst_i;
                        if (last_beat) begin
                            read_q  <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (resp_i && last_beat) begin
                        write_q <= 1'b0;
                        resp_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Requests are not looked at here, so a still-held
                    // request cannot restart a burst in the same cycle.
                    resp_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BEATS; gi++) begin : g_line_out
            assign line_o[gi*S_BURST +: S_BURST] = line_q[gi];
        end
    endgenerate

    // Write data follows the beat counter directly so stalls hold it stable.
    assign burst_o   = (state_q == WR_BURST) ? wbuf_q[count] : '0;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;

endmodule
